// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// ID-stage hazard unit for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// Detects RAW hazards for both ID source operands against the EX and MEM
// producers, drives registered forwarding selects for the EX stage, inserts
// LOAD_USE_BUBBLES bubbles per load-use hazard, stalls on a busy mult/div unit
// and gives a taken branch priority over every stall source.
//
// Optional feature macro: HAZARD_STATS_EN (saturating stall/forward counters).
// When undefined the statistics ports are tied to zero.
//
// Ports:
//   CLK, CLR            clock (rising edge), synchronous active-high reset
//   R1Adr/R2Adr         ID operand addresses; R1Used/R2Used operand is read
//   MdReq/MdBusy        ID needs mult/div; mult/div unit busy
//   EX_WAdr, EX_RegWrite, EX_MemToReg   producer in EX
//   MEM_WAdr, MEM_RegWrite              producer in MEM
//   BranchTaken         branch resolved taken in EX
//   Stall_PC_ID, Bubble_EX, Flush_IF_ID pipeline control (combinational)
//   R1_Fwd/R2_Fwd       registered EX operand selects (00 rf, 01 EX/MEM, 10 MEM/WB)
//   Stat_Stalls/Stat_Fwds statistics counters
module pipeline_hazard_unit #(
    parameter int unsigned ADR_W            = 5,
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned STAT_W           = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADR_W-1:0]  R1Adr,
    input  logic [ADR_W-1:0]  R2Adr,
    input  logic              R1Used,
    input  logic              R2Used,
    input  logic              MdReq,
    input  logic              MdBusy,
    input  logic [ADR_W-1:0]  EX_WAdr,
    input  logic              EX_RegWrite,
    input  logic              EX_MemToReg,
    input  logic [ADR_W-1:0]  MEM_WAdr,
    input  logic              MEM_RegWrite,
    input  logic              BranchTaken,
    output logic              Stall_PC_ID,
    output logic              Bubble_EX,
    output logic              Flush_IF_ID,
    output logic [1:0]        R1_Fwd,
    output logic [1:0]        R2_Fwd,
    output logic [STAT_W-1:0] Stat_Stalls,
    output logic [STAT_W-1:0] Stat_Fwds
);

    typedef enum logic [1:0] {StIdle, StLuStall, StMdWait} state_e;

    // First bubble is issued from StIdle, the rest are counted in StLuStall.
    localparam logic [2:0] LuInit = 3'(LOAD_USE_BUBBLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] r1_fwd_q, r1_fwd_d, r2_fwd_q, r2_fwd_d;

    logic r1_exm, r2_exm, r1_memm, r2_memm, lu;

    // Register 0 is hardwired zero and never produces a hazard.
    assign r1_exm  = R1Used & EX_RegWrite & (EX_WAdr != '0) & (EX_WAdr == R1Adr);
    assign r2_exm  = R2Used & EX_RegWrite & (EX_WAdr != '0) & (EX_WAdr == R2Adr);
    assign r1_memm = R1Used & MEM_RegWrite & (MEM_WAdr != '0) & (MEM_WAdr == R1Adr);
    assign r2_memm = R2Used & MEM_RegWrite & (MEM_WAdr != '0) & (MEM_WAdr == R2Adr);
    assign lu      = EX_MemToReg & (r1_exm | r2_exm);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        Stall_PC_ID = 1'b0;
        Bubble_EX   = 1'b0;
        Flush_IF_ID = 1'b0;
        if (CLR) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (BranchTaken) begin
            // PC must load the target, so the flush overrides any stall.
            Flush_IF_ID = 1'b1;
            Bubble_EX   = 1'b1;
            state_d     = StIdle;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lu) begin
                        Stall_PC_ID = 1'b1;
                        Bubble_EX   = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = StLuStall;
                            cnt_d   = LuInit;
                        end
                    end else if (MdReq && MdBusy) begin
                        Stall_PC_ID = 1'b1;
                        Bubble_EX   = 1'b1;
                        state_d     = StMdWait;
                    end
                end
                StLuStall: begin
                    Stall_PC_ID = 1'b1;
                    Bubble_EX   = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StMdWait: begin
                    if (MdBusy) begin
                        Stall_PC_ID = 1'b1;
                        Bubble_EX   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // EX producer is newer than MEM; a load in EX cannot forward (it stalls instead).
    always_comb begin
        r1_fwd_d = 2'b00;
        r2_fwd_d = 2'b00;
        if (!CLR && !Bubble_EX && !Stall_PC_ID) begin
            if (r1_exm && !EX_MemToReg) r1_fwd_d = 2'b01;
            else if (r1_memm)           r1_fwd_d = 2'b10;
            if (r2_exm && !EX_MemToReg) r2_fwd_d = 2'b01;
            else if (r2_memm)           r2_fwd_d = 2'b10;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            r1_fwd_q <= 2'b00;
            r2_fwd_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r1_fwd_q <= r1_fwd_d;
            r2_fwd_q <= r2_fwd_d;
        end
    end

    assign R1_Fwd = r1_fwd_q;
    assign R2_Fwd = r2_fwd_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stalls_q, fwds_q;
    logic [1:0]        n_fwd;
    logic [STAT_W:0]   fwd_sum;

    assign n_fwd   = {1'b0, |r1_fwd_d} + {1'b0, |r2_fwd_d};
    assign fwd_sum = {1'b0, fwds_q} + (STAT_W + 1)'(n_fwd);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            stalls_q <= '0;
            fwds_q   <= '0;
        end else begin
            if (Stall_PC_ID && !(&stalls_q)) stalls_q <= stalls_q + 1'b1;
            // Adding up to 2 may overshoot all-ones; clamp on carry-out.
            fwds_q <= fwd_sum[STAT_W] ? '1 : fwd_sum[STAT_W-1:0];
        end
    end

    assign Stat_Stalls = stalls_q;
    assign Stat_Fwds   = fwds_q;
`else
    assign Stat_Stalls = '0;
    assign Stat_Fwds   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

`ifdef HAZARD_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR;
    logic [4:0] R1Adr, R2Adr, EX_WAdr, MEM_WAdr;
    logic       R1Used, R2Used, MdReq, MdBusy;
    logic       EX_RegWrite, EX_MemToReg, MEM_RegWrite, BranchTaken;

    logic        stall_o[2], bubble_o[2], flush_o[2];
    logic [1:0]  f1_o[2], f2_o[2];
    logic [15:0] sa_s, sa_f;
    logic [3:0]  sb_s, sb_f;
    logic [15:0] ss_o[2], sf_o[2];

    assign ss_o[0] = sa_s;
    assign sf_o[0] = sa_f;
    assign ss_o[1] = {12'd0, sb_s};
    assign sf_o[1] = {12'd0, sb_f};

    always #5 CLK = ~CLK;

    pipeline_hazard_unit #(.ADR_W(5), .LOAD_USE_BUBBLES(1), .STAT_W(16)) dut_a (
        .CLK(CLK), .CLR(CLR), .R1Adr(R1Adr), .R2Adr(R2Adr), .R1Used(R1Used),
        .R2Used(R2Used), .MdReq(MdReq), .MdBusy(MdBusy), .EX_WAdr(EX_WAdr),
        .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg), .MEM_WAdr(MEM_WAdr),
        .MEM_RegWrite(MEM_RegWrite), .BranchTaken(BranchTaken),
        .Stall_PC_ID(stall_o[0]), .Bubble_EX(bubble_o[0]), .Flush_IF_ID(flush_o[0]),
        .R1_Fwd(f1_o[0]), .R2_Fwd(f2_o[0]), .Stat_Stalls(sa_s), .Stat_Fwds(sa_f)
    );

    // Small STAT_W so saturation is reached within the run.
    pipeline_hazard_unit #(.ADR_W(5), .LOAD_USE_BUBBLES(3), .STAT_W(4)) dut_b (
        .CLK(CLK), .CLR(CLR), .R1Adr(R1Adr), .R2Adr(R2Adr), .R1Used(R1Used),
        .R2Used(R2Used), .MdReq(MdReq), .MdBusy(MdBusy), .EX_WAdr(EX_WAdr),
        .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg), .MEM_WAdr(MEM_WAdr),
        .MEM_RegWrite(MEM_RegWrite), .BranchTaken(BranchTaken),
        .Stall_PC_ID(stall_o[1]), .Bubble_EX(bubble_o[1]), .Flush_IF_ID(flush_o[1]),
        .R1_Fwd(f1_o[1]), .R2_Fwd(f2_o[1]), .Stat_Stalls(sb_s), .Stat_Fwds(sb_f)
    );

    // Reference model: bubbles still owed, waiting-on-mult/div flag, forward selects.
    int nb[2]   = '{1, 3};
    int smax[2] = '{65535, 15};
    int owed[2], m_ss[2], m_sf[2];
    bit md_wait[2];
    int m_f1[2], m_f2[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sel(input logic [4:0] adr, input logic used);
        if (used && EX_RegWrite && EX_WAdr != 0 && EX_WAdr == adr && !EX_MemToReg) return 1;
        if (used && MEM_RegWrite && MEM_WAdr != 0 && MEM_WAdr == adr) return 2;
        return 0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle with the currently driven inputs.
    task automatic step();
        int n_owed[2], n_f1[2], n_f2[2], n_ss[2], n_sf[2];
        bit n_md[2];
        bit lu;
        #2;
        lu = EX_MemToReg && EX_RegWrite && EX_WAdr != 0 &&
             ((R1Used && EX_WAdr == R1Adr) || (R2Used && EX_WAdr == R2Adr));
        for (int i = 0; i < 2; i++) begin
            bit st, bu, fl;
            st = 0; bu = 0; fl = 0;
            n_owed[i] = owed[i];
            n_md[i]   = md_wait[i];
            if (CLR) begin
                n_owed[i] = 0;
                n_md[i]   = 0;
            end else if (BranchTaken) begin
                fl = 1; bu = 1;
                n_owed[i] = 0;
                n_md[i]   = 0;
            end else if (owed[i] > 0) begin
                st = 1; bu = 1;
                n_owed[i] = owed[i] - 1;
            end else if (md_wait[i]) begin
                if (MdBusy) begin st = 1; bu = 1; end
                else n_md[i] = 0;
            end else if (lu) begin
                st = 1; bu = 1;
                n_owed[i] = nb[i] - 1;
            end else if (MdReq && MdBusy) begin
                st = 1; bu = 1;
                n_md[i] = 1;
            end
            check($sformatf("stall%0d", i), 32'(stall_o[i]), 32'(st));
            check($sformatf("bubble%0d", i), 32'(bubble_o[i]), 32'(bu));
            check($sformatf("flush%0d", i), 32'(flush_o[i]), 32'(fl));
            if (CLR || st || bu) begin
                n_f1[i] = 0;
                n_f2[i] = 0;
            end else begin
                n_f1[i] = sel(R1Adr, R1Used);
                n_f2[i] = sel(R2Adr, R2Used);
            end
            if (CLR) begin
                n_ss[i] = 0;
                n_sf[i] = 0;
            end else begin
                n_ss[i] = sat(m_ss[i] + int'(st), smax[i]);
                n_sf[i] = sat(m_sf[i] + int'(n_f1[i] != 0) + int'(n_f2[i] != 0), smax[i]);
            end
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            owed[i] = n_owed[i]; md_wait[i] = n_md[i];
            m_f1[i] = n_f1[i];   m_f2[i] = n_f2[i];
            m_ss[i] = n_ss[i];   m_sf[i] = n_sf[i];
            check($sformatf("r1fwd%0d", i), 32'(f1_o[i]), 32'(m_f1[i]));
            check($sformatf("r2fwd%0d", i), 32'(f2_o[i]), 32'(m_f2[i]));
            check($sformatf("stalls%0d", i), 32'(ss_o[i]), StatsOn ? 32'(m_ss[i]) : 32'd0);
            check($sformatf("fwds%0d", i), 32'(sf_o[i]), StatsOn ? 32'(m_sf[i]) : 32'd0);
        end
    endtask

    task automatic quiet();
        CLR = 0; R1Adr = 0; R2Adr = 0; R1Used = 0; R2Used = 0; MdReq = 0; MdBusy = 0;
        EX_WAdr = 0; EX_RegWrite = 0; EX_MemToReg = 0; MEM_WAdr = 0; MEM_RegWrite = 0;
        BranchTaken = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            owed[i] = 0; md_wait[i] = 0; m_f1[i] = 0; m_f2[i] = 0; m_ss[i] = 0; m_sf[i] = 0;
        end
        quiet();
        CLR = 1;
        step();
        step();
        CLR = 0;
        // Load-use on $3, then the load moves to MEM.
        EX_WAdr = 3; EX_RegWrite = 1; EX_MemToReg = 1; R1Adr = 3; R1Used = 1;
        step();
        EX_RegWrite = 0; EX_MemToReg = 0; MEM_WAdr = 3; MEM_RegWrite = 1;
        step();
        step();
        step();
        // EX and MEM both write $5: newest wins; then operand unused.
        quiet();
        EX_WAdr = 5; EX_RegWrite = 1; MEM_WAdr = 5; MEM_RegWrite = 1; R2Adr = 5; R2Used = 1;
        step();
        R2Used = 0;
        step();
        // Writes to $0 never hazard.
        quiet();
        EX_WAdr = 0; EX_RegWrite = 1; EX_MemToReg = 1; R1Adr = 0; R1Used = 1;
        step();
        // Load-use with a taken branch in the second stall cycle.
        quiet();
        EX_WAdr = 7; EX_RegWrite = 1; EX_MemToReg = 1; R2Adr = 7; R2Used = 1;
        step();
        quiet();
        BranchTaken = 1;
        step();
        BranchTaken = 0;
        step();
        // Mult/div busy for 4 cycles, then release.
        MdReq = 1; MdBusy = 1;
        repeat (4) step();
        MdBusy = 0;
        step();
        step();
        // Reset in the middle of a mult/div wait.
        MdBusy = 1;
        step();
        step();
        CLR = 1;
        step();
        CLR = 0;
        step();
        quiet();
        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            CLR          = ($urandom_range(0, 99) == 0);
            BranchTaken  = ($urandom_range(0, 15) == 0);
            R1Adr        = 5'($urandom_range(0, 3));
            R2Adr        = 5'($urandom_range(0, 3));
            EX_WAdr      = 5'($urandom_range(0, 3));
            MEM_WAdr     = 5'($urandom_range(0, 3));
            R1Used       = ($urandom_range(0, 3) != 0);
            R2Used       = ($urandom_range(0, 3) != 0);
            EX_RegWrite  = ($urandom_range(0, 3) != 0);
            EX_MemToReg  = ($urandom_range(0, 2) == 0);
            MEM_RegWrite = ($urandom_range(0, 3) != 0);
            MdReq        = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) MdBusy = ~MdBusy;
            step();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
